// File: rtl/ibuf_mcast_fifo_ctrl_pkg.sv
// Shared definitions for the multicast input-buffer controller: direction
// codes (bit index of a route mask) and default flit field widths.
package ibuf_mcast_fifo_ctrl_pkg;

  // Direction code doubles as the bit position in route/request masks.
  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_W = 3'd1,
    DIR_S = 3'd2,
    DIR_E = 3'd3,
    DIR_B = 3'd4
  } dir_e;

  localparam int NDIR_DEF   = 5;
  localparam int PYLD_W_DEF = 23;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/sync_fifo_ring.sv
// Ring-buffer FIFO holding the entries queued behind the head register.
// Pointers wrap modulo N_ENT, so N_ENT need not be a power of two.
// Storage is not reset; only pointers and count are.
module sync_fifo_ring #(
  parameter int W     = 28,
  parameter int N_ENT = 3,
  parameter int CNT_W = $clog2(N_ENT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_ENT - 1);

  logic [W-1:0]     mem [N_ENT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign rd_data = mem[rd_ptr];

  // Entry write; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; reset drops every queued entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {{(CNT_W-1){1'b0}}, wr_en} - {{(CNT_W-1){1'b0}}, rd_en};
    end
  end

endmodule

// File: rtl/ibuf_mcast_fifo_ctrl.sv
// Multicast input-buffer controller. The head flit lives in dedicated
// registers (arb_req/payload_o); the remaining DEPTH-1 entries queue in a
// ring FIFO. Each pending request bit retires independently on a grant with
// a ready output buffer, or is suppressed (and counted) when its destination
// is dead in copy mode. The head pops once no bit remains pending.
//
// Handshake: a flit transfers on any edge where ibuf_vld & ibuf_rdy; ibuf_rdy
// is registered and only asserted when the accept cannot overflow. A request
// bit transfers on arb_gnt & obuf_rdy & arb_req; grants on idle bits are ignored.
module ibuf_mcast_fifo_ctrl
  import ibuf_mcast_fifo_ctrl_pkg::*;
#(
  parameter  int PYLD_W = PYLD_W_DEF,
  parameter  int NDIR   = NDIR_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_en,
  input  logic              cpy_mode,
  input  logic [NDIR-1:0]   dead_mask,
  input  logic              ibuf_vld,
  output logic              ibuf_rdy,
  input  logic [NDIR-1:0]   route_req,
  input  logic [PYLD_W-1:0] payload_i,
  output logic [NDIR-1:0]   arb_req,
  input  logic [NDIR-1:0]   arb_gnt,
  input  logic [NDIR-1:0]   obuf_rdy,
  output logic [PYLD_W-1:0] payload_o,
  output logic [CNT_W-1:0]  occupancy,
  output logic [15:0]       drop_cnt
);

  localparam int FLIT_W = NDIR + PYLD_W;
  localparam int FC_W   = $clog2(DEPTH);
  localparam int KC_W   = $clog2(NDIR + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_next;
  logic              head_vld;
  logic              stall_mode;
  logic [NDIR-1:0]   clr;
  logic [NDIR-1:0]   kill;
  logic [NDIR-1:0]   rem;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;
  logic              head_from_fifo;
  logic              head_from_in;
  logic              fifo_wr;
  logic [FLIT_W-1:0] fifo_rd_data;
  logic [FC_W-1:0]   fifo_cnt;
  logic [KC_W-1:0]   kill_cnt;
  logic [16:0]       drop_sum;

  function automatic logic [KC_W-1:0] popcount(input logic [NDIR-1:0] v);
    logic [KC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NDIR; i++) c = c + {{(KC_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  assign occupancy  = occ_q;
  assign head_vld   = (occ_q != '0);
  assign stall_mode = pg_en & cpy_mode;

  // Per-bit retirement: granted bits clear, dead-destination bits are killed.
  assign clr  = arb_gnt & obuf_rdy & arb_req;
  assign kill = stall_mode ? (arb_req & dead_mask) : '0;
  assign rem  = arb_req & ~clr & ~kill;

  // A head with nothing left pending (including a route_req==0 flit) pops.
  assign pop  = head_vld & (rem == '0);
  assign push = ibuf_vld & ibuf_rdy;

  // Refill the head from the queue first; an incoming flit goes straight to
  // the head only when nothing else is waiting behind it.
  assign fifo_nonempty  = (fifo_cnt != '0);
  assign head_from_fifo = pop & fifo_nonempty;
  assign head_from_in   = push & (~head_vld | (pop & ~fifo_nonempty));
  assign fifo_wr        = push & ~head_from_in;

  assign occ_next = occ_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  assign kill_cnt = popcount(kill);
  assign drop_sum = {1'b0, drop_cnt} + {{(17-KC_W){1'b0}}, kill_cnt};

  sync_fifo_ring #(
    .W     (FLIT_W),
    .N_ENT (DEPTH - 1),
    .CNT_W (FC_W)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({route_req, payload_i}),
    .rd_en   (head_from_fifo),
    .rd_data (fifo_rd_data),
    .count   (fifo_cnt)
  );

  // Head registers: load on pop/empty-push, otherwise retire pending bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arb_req   <= '0;
      payload_o <= '0;
    end else if (head_from_fifo) begin
      {arb_req, payload_o} <= fifo_rd_data;
    end else if (head_from_in) begin
      arb_req   <= route_req;
      payload_o <= payload_i;
    end else begin
      arb_req <= rem;
    end
  end

  // Occupancy, registered ready (stalled in copy mode) and saturating drop count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= '0;
      ibuf_rdy <= 1'b1;
      drop_cnt <= '0;
    end else begin
      occ_q    <= occ_next;
      ibuf_rdy <= ~stall_mode & (occ_next < DEPTH_C);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_ibuf_mcast_fifo_ctrl.sv
// Bench for ibuf_mcast_fifo_ctrl: directed vector table, hand sequences for
// long stalls and mid-operation reset, and a randomized scoreboard run.
module tb_ibuf_mcast_fifo_ctrl;
  import ibuf_mcast_fifo_ctrl_pkg::*;

  localparam int PW = 23;
  localparam int ND = 5;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          pg_en;
  logic          cpy_mode;
  logic [ND-1:0] dead_mask;
  logic          ibuf_vld;
  logic          ibuf_rdy;
  logic [ND-1:0] route_req;
  logic [PW-1:0] payload_i;
  logic [ND-1:0] arb_req;
  logic [ND-1:0] arb_gnt;
  logic [ND-1:0] obuf_rdy;
  logic [PW-1:0] payload_o;
  logic [CW-1:0] occupancy;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ibuf_mcast_fifo_ctrl #(.PYLD_W(PW), .NDIR(ND), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pg_en     (pg_en),
    .cpy_mode  (cpy_mode),
    .dead_mask (dead_mask),
    .ibuf_vld  (ibuf_vld),
    .ibuf_rdy  (ibuf_rdy),
    .route_req (route_req),
    .payload_i (payload_i),
    .arb_req   (arb_req),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .payload_o (payload_o),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ibuf_vld  = 1'b0;
    route_req = '0;
    payload_i = '0;
    arb_gnt   = '0;
    obuf_rdy  = '0;
    pg_en     = 1'b0;
    cpy_mode  = 1'b0;
    dead_mask = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_flit(input logic [ND-1:0] r, input logic [PW-1:0] p);
    ibuf_vld  = 1'b1;
    route_req = r;
    payload_i = p;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [ND-1:0] e_req, input logic [PW-1:0] e_pld,
                          input logic [CW-1:0] e_occ, input logic e_rdy, input logic [15:0] e_drop);
    chk({tag, ".arb_req"},   32'(arb_req),   32'(e_req));
    chk({tag, ".payload_o"}, 32'(payload_o), 32'(e_pld));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(e_occ));
    chk({tag, ".ibuf_rdy"},  32'(ibuf_rdy),  32'(e_rdy));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(e_drop));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          vld;
    logic [ND-1:0] route;
    logic [PW-1:0] pld;
    logic [ND-1:0] gnt;
    logic [ND-1:0] ordy;
    logic          pg;
    logic          cpy;
    logic [ND-1:0] dead;
    logic [ND-1:0] e_req;
    logic [PW-1:0] e_pld;
    logic [CW-1:0] e_occ;
    logic          e_rdy;
    logic [15:0]   e_drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [ND-1:0] r, input logic [PW-1:0] p,
                     input logic [ND-1:0] g, input logic [ND-1:0] o,
                     input logic pg, input logic cp, input logic [ND-1:0] d,
                     input logic [ND-1:0] er, input logic [PW-1:0] ep,
                     input logic [CW-1:0] eo, input logic erdy, input logic [15:0] edr);
    vec_t t;
    t.vld = v; t.route = r; t.pld = p; t.gnt = g; t.ordy = o;
    t.pg = pg; t.cpy = cp; t.dead = d;
    t.e_req = er; t.e_pld = ep; t.e_occ = eo; t.e_rdy = erdy; t.e_drop = edr;
    tbl.push_back(t);
  endtask

  // ---------------- scoreboard model state ----------------
  logic [ND+PW-1:0] exp_q[$];
  logic [ND-1:0]    m_pend;
  logic [PW-1:0]    m_pld;
  logic             m_rdy;

  initial begin
    logic          s_push;
    logic          s_pop;
    logic [ND-1:0] s_rem;
    int            old_sz;

    drive_idle();
    rst_n = 1'b0;
    do_reset();
    chk_outs("reset", 5'b00000, 23'h0, 3'd0, 1'b1, 16'd0);

    //   vld route     pld     gnt       ordy      pg cpy dead     e_req     e_pld   occ rdy drop
    // single unicast flit, then grant
    add(1, 5'b00001, 23'h01, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 23'h01, 1, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b00001, 5'b11111, 0, 0, 5'b00000, 5'b00000, 23'h01, 0, 1, 0);
    // multicast with independent grants, second flit queued behind
    add(1, 5'b10101, 23'h22, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b10101, 23'h22, 1, 1, 0);
    add(1, 5'b00010, 23'h33, 5'b00001, 5'b11111, 0, 0, 5'b00000, 5'b10100, 23'h22, 2, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b11111, 0, 0, 5'b00000, 5'b10100, 23'h22, 2, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b10000, 5'b11111, 0, 0, 5'b00000, 5'b00100, 23'h22, 2, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b00100, 5'b11111, 0, 0, 5'b00000, 5'b00010, 23'h33, 1, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b00010, 5'b11111, 0, 0, 5'b00000, 5'b00000, 23'h33, 0, 1, 0);
    // fill to DEPTH, blocked push, pop, push+pop, drain
    add(1, 5'b00001, 23'h41, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 23'h41, 1, 1, 0);
    add(1, 5'b00010, 23'h42, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 23'h41, 2, 1, 0);
    add(1, 5'b00100, 23'h43, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 23'h41, 3, 1, 0);
    add(1, 5'b01000, 23'h44, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 23'h41, 4, 0, 0);
    add(1, 5'b10000, 23'h55, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 23'h41, 4, 0, 0);
    add(0, 5'b00000, 23'h00, 5'b00001, 5'b11111, 0, 0, 5'b00000, 5'b00010, 23'h42, 3, 1, 0);
    add(1, 5'b10000, 23'h45, 5'b00010, 5'b11111, 0, 0, 5'b00000, 5'b00100, 23'h43, 3, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b00100, 5'b11111, 0, 0, 5'b00000, 5'b01000, 23'h44, 2, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b01000, 5'b11111, 0, 0, 5'b00000, 5'b10000, 23'h45, 1, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b10000, 5'b11111, 0, 0, 5'b00000, 5'b00000, 23'h45, 0, 1, 0);
    // copy mode: dead W suppressed, stall, release
    add(1, 5'b01010, 23'h66, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b01010, 23'h66, 1, 1, 0);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b00000, 1, 1, 5'b00010, 5'b01000, 23'h66, 1, 0, 1);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b00000, 1, 1, 5'b00010, 5'b01000, 23'h66, 1, 0, 1);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b00000, 1, 0, 5'b00010, 5'b01000, 23'h66, 1, 1, 1);
    add(0, 5'b00000, 23'h00, 5'b01000, 5'b11111, 1, 0, 5'b00010, 5'b00000, 23'h66, 0, 1, 1);
    // head fully killed retires without a grant
    add(1, 5'b00100, 23'h77, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00100, 23'h77, 1, 1, 1);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b00000, 1, 1, 5'b00100, 5'b00000, 23'h77, 0, 0, 2);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 23'h77, 0, 1, 2);
    // route_req==0 flit: loads head without requesting, then discarded
    add(1, 5'b00000, 23'h88, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 23'h88, 1, 1, 2);
    add(0, 5'b00000, 23'h00, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 23'h88, 0, 1, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      ibuf_vld  = tbl[i].vld;
      route_req = tbl[i].route;
      payload_i = tbl[i].pld;
      arb_gnt   = tbl[i].gnt;
      obuf_rdy  = tbl[i].ordy;
      pg_en     = tbl[i].pg;
      cpy_mode  = tbl[i].cpy;
      dead_mask = tbl[i].dead;
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_pld, tbl[i].e_occ,
               tbl[i].e_rdy, tbl[i].e_drop);
    end

    // ---- long obuf back-pressure: grants on all bits must not retire anything ----
    drive_idle();
    push_flit(5'b00011, 23'h99);
    tick();
    drive_idle();
    arb_gnt  = 5'b11111;
    obuf_rdy = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp%0d.arb_req", i), 32'(arb_req), 32'h03);
      chk($sformatf("bp%0d.payload_o", i), 32'(payload_o), 32'h99);
    end
    obuf_rdy = 5'b00001;
    tick();
    chk("bp_n.arb_req", 32'(arb_req), 32'h02);
    obuf_rdy = 5'b11111;
    tick();
    chk("bp_done.occupancy", 32'(occupancy), 32'd0);
    chk("bp_done.arb_req", 32'(arb_req), 32'd0);

    // ---- reset mid-operation with three entries held ----
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      push_flit(5'b00001, 23'(32'hA1 + i));
      tick();
    end
    drive_idle();
    chk("pre_rst.occupancy", 32'(occupancy), 32'd3);
    push_flit(5'b10000, 23'h5A);
    rst_n = 1'b0;
    tick();
    chk_outs("mid_rst", 5'b00000, 23'h0, 3'd0, 1'b1, 16'd0);
    rst_n = 1'b1;
    drive_idle();
    tick();
    chk("post_rst.occupancy", 32'(occupancy), 32'd0);
    chk("post_rst.arb_req", 32'(arb_req), 32'd0);
    push_flit(5'b00100, 23'hAB);
    tick();
    drive_idle();
    chk_outs("post_rst_push", 5'b00100, 23'hAB, 3'd1, 1'b1, 16'd0);
    arb_gnt  = 5'b00100;
    obuf_rdy = 5'b11111;
    tick();
    drive_idle();
    tick();
    chk("post_rst_drain.occupancy", 32'(occupancy), 32'd0);
    chk("post_rst_drain.arb_req", 32'(arb_req), 32'd0);

    // ---- randomized scoreboard run ----
    do_reset();
    exp_q.delete();
    m_pend = '0;
    m_pld  = '0;
    m_rdy  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      ibuf_vld  = ($urandom_range(0, 3) != 0);
      route_req = ($urandom_range(0, 15) == 0) ? 5'b00000 : ND'($urandom_range(1, 31));
      payload_i = PW'($urandom);
      arb_gnt   = ND'($urandom_range(0, 31));
      obuf_rdy  = ND'($urandom_range(0, 31) | $urandom_range(0, 31));

      s_push = ibuf_vld & m_rdy;
      old_sz = exp_q.size();
      s_pop  = 1'b0;
      s_rem  = '0;
      if (old_sz != 0) begin
        s_rem = m_pend & ~(arb_gnt & obuf_rdy);
        s_pop = (s_rem == '0);
      end
      if (s_pop) void'(exp_q.pop_front());
      if (s_push) exp_q.push_back({route_req, payload_i});
      if ((old_sz == 0 || s_pop) && exp_q.size() != 0) begin
        m_pend = exp_q[0][ND+PW-1:PW];
        m_pld  = exp_q[0][PW-1:0];
      end else begin
        m_pend = s_rem;
      end
      m_rdy = (exp_q.size() < DP);

      tick();
      chk($sformatf("rnd%0d.arb_req", c),   32'(arb_req),   32'(m_pend));
      chk($sformatf("rnd%0d.payload_o", c), 32'(payload_o), 32'(m_pld));
      chk($sformatf("rnd%0d.occupancy", c), 32'(occupancy), 32'(exp_q.size()));
      chk($sformatf("rnd%0d.ibuf_rdy", c),  32'(ibuf_rdy),  32'(m_rdy));
    end

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
